// File: rtl/xmit_gen_pkg.sv
// Shared types and constants for the xmit-path frame generator.
package xmit_gen_pkg;

  typedef enum logic [1:0] {
    MODE_FILL  = 2'd0,
    MODE_INCR  = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_CONST = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting register (bits 7,5,4,3).
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'hFF;
  localparam logic [7:0] FILL_EDGE = 8'h00;
  localparam logic [7:0] FILL_BODY = 8'hFF;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/xmit_pattern_gen.sv
// Payload byte generator; the LFSR only advances when a byte is actually issued.
module xmit_pattern_gen
  import xmit_gen_pkg::*;
#(
  parameter int LEN_W      = 12,
  parameter int EDGE_BYTES = 4
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  mode_e            mode,
  input  logic [LEN_W-1:0] idx,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       fill,
  input  logic             advance,
  output logic [7:0]       pat_byte
);

  localparam logic [LEN_W-1:0] EDGE = LEN_W'(EDGE_BYTES);

  logic [7:0] lfsr;
  logic [7:0] lfsr_cur;

  // Byte 0 of every frame restarts from the seed regardless of register contents.
  assign lfsr_cur = (idx == '0) ? LFSR_SEED : lfsr;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (advance) begin
      lfsr <= lfsr_step(lfsr_cur);
    end
  end

  always_comb begin
    pat_byte = 8'h00;
    unique case (mode)
      MODE_FILL:  pat_byte = (idx < EDGE || idx >= len - EDGE) ? FILL_EDGE : FILL_BODY;
      MODE_INCR:  pat_byte = 8'(idx);
      MODE_LFSR:  pat_byte = lfsr_cur;
      MODE_CONST: pat_byte = fill;
      default:    pat_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/xmit_frame_gen.sv
// Configurable burst frame source feeding xmitTop; all outputs are registered.
module xmit_frame_gen
  import xmit_gen_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 12,
  parameter int CNT_W      = 8,
  parameter int EDGE_BYTES = 4,
  parameter int MIN_LEN    = 8
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               cfg_start,
  input  logic               cfg_stop,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_count,
  input  logic [CNT_W-1:0]   cfg_gap,
  input  logic [1:0]         cfg_mode,
  input  logic [7:0]         cfg_fill,
  input  logic               cfg_hi_pri,
  input  logic               cfg_pri_alt,
  input  logic               gen_stall,
  output logic [DATA_W-1:0]  gen_data,
  output logic               gen_data_valid,
  output logic               gen_frame_valid,
  output logic [2*LEN_W-1:0] gen_ctrl,
  output logic               gen_hi_priority,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   frames_sent
);

  localparam logic [LEN_W-1:0] MIN_LEN_V = LEN_W'(MIN_LEN);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, idx_q, idx_d, issue_idx, run_len, start_len;
  logic [CNT_W-1:0] count_q, gap_q, gcnt_q, gcnt_d, sent_d, sent_inc;
  mode_e            mode_q, run_mode;
  logic [7:0]       fill_q, run_fill, pat_byte;
  logic             hi_q, alt_q, odd_q, odd_d, stop_q, stop_d, stop_eff;
  logic             issue, end_run, start_run, issue_pri;

  // In IDLE the first byte is issued straight from the cfg inputs being latched.
  assign start_len = (cfg_len < MIN_LEN_V) ? MIN_LEN_V : cfg_len;
  assign start_run = (state_q == ST_IDLE) && cfg_start;
  assign run_len   = (state_q == ST_IDLE) ? start_len : len_q;
  assign run_mode  = (state_q == ST_IDLE) ? mode_e'(cfg_mode) : mode_q;
  assign run_fill  = (state_q == ST_IDLE) ? cfg_fill : fill_q;
  assign stop_eff  = stop_q | cfg_stop;
  assign sent_inc  = frames_sent + CNT_W'(1);
  assign issue_pri = ((state_q == ST_IDLE) ? cfg_hi_pri : hi_q) ^
                     (((state_q == ST_IDLE) ? cfg_pri_alt : alt_q) & odd_d);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gcnt_d    = gcnt_q;
    sent_d    = frames_sent;
    odd_d     = odd_q;
    stop_d    = stop_q | (cfg_stop && state_q != ST_IDLE);
    issue     = 1'b0;
    issue_idx = '0;
    end_run   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          state_d = ST_DATA;
          issue   = 1'b1;
          idx_d   = LEN_W'(1);
          sent_d  = '0;
          odd_d   = 1'b0;
        end
      end
      ST_DATA: begin
        // idx_q == len_q means the last byte is on the outputs this cycle.
        if (idx_q == len_q) begin
          sent_d = sent_inc;
          odd_d  = ~odd_q;
          if ((count_q != '0 && sent_inc == count_q) || stop_eff) begin
            end_run = 1'b1;
          end else if (gap_q != '0) begin
            state_d = ST_GAP;
            gcnt_d  = gap_q;
          end else if (!gen_stall) begin
            issue = 1'b1;
            idx_d = LEN_W'(1);
          end else begin
            idx_d = '0;
          end
        end else if (!gen_stall) begin
          issue     = 1'b1;
          issue_idx = idx_q;
          idx_d     = idx_q + LEN_W'(1);
        end
      end
      ST_GAP: begin
        if (gcnt_q == CNT_W'(1)) begin
          if (stop_eff) begin
            end_run = 1'b1;
          end else begin
            state_d = ST_DATA;
            if (!gen_stall) begin
              issue = 1'b1;
              idx_d = LEN_W'(1);
            end else begin
              idx_d = '0;
            end
          end
        end else begin
          gcnt_d = gcnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (end_run) begin
      state_d = ST_IDLE;
      stop_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      gcnt_q      <= '0;
      odd_q       <= 1'b0;
      stop_q      <= 1'b0;
      frames_sent <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gcnt_q      <= gcnt_d;
      odd_q       <= odd_d;
      stop_q      <= stop_d;
      frames_sent <= sent_d;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      len_q           <= '0;
      count_q         <= '0;
      gap_q           <= '0;
      mode_q          <= MODE_FILL;
      fill_q          <= '0;
      hi_q            <= 1'b0;
      alt_q           <= 1'b0;
      gen_data        <= '0;
      gen_data_valid  <= 1'b0;
      gen_frame_valid <= 1'b0;
      gen_ctrl        <= '0;
      gen_hi_priority <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      if (start_run) begin
        len_q   <= start_len;
        count_q <= cfg_count;
        gap_q   <= cfg_gap;
        mode_q  <= mode_e'(cfg_mode);
        fill_q  <= cfg_fill;
        hi_q    <= cfg_hi_pri;
        alt_q   <= cfg_pri_alt;
      end
      gen_data        <= issue ? {(DATA_W/8){pat_byte}} : '0;
      gen_data_valid  <= issue;
      gen_frame_valid <= issue && (issue_idx == '0);
      gen_ctrl        <= (issue && issue_idx == '0) ? {run_len, run_len} : '0;
      if (issue) begin
        gen_hi_priority <= issue_pri;
      end else if (end_run) begin
        gen_hi_priority <= 1'b0;
      end
      busy <= (state_d != ST_IDLE);
      done <= end_run;
    end
  end

  xmit_pattern_gen #(
    .LEN_W      (LEN_W),
    .EDGE_BYTES (EDGE_BYTES)
  ) u_pattern (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .mode     (run_mode),
    .idx      (issue_idx),
    .len      (run_len),
    .fill     (run_fill),
    .advance  (issue),
    .pat_byte (pat_byte)
  );

endmodule

// File: tb/tb_xmit_frame_gen.sv
// Directed scenario bench for xmit_frame_gen with hand-computed expected bytes.
module tb_xmit_frame_gen;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 12;
  localparam int CNT_W  = 8;

  logic               clk_sys = 1'b0;
  logic               reset = 1'b1;
  logic               cfg_start = 1'b0;
  logic               cfg_stop = 1'b0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic [CNT_W-1:0]   cfg_count = '0;
  logic [CNT_W-1:0]   cfg_gap = '0;
  logic [1:0]         cfg_mode = '0;
  logic [7:0]         cfg_fill = '0;
  logic               cfg_hi_pri = 1'b0;
  logic               cfg_pri_alt = 1'b0;
  logic               gen_stall = 1'b0;
  logic [DATA_W-1:0]  gen_data;
  logic               gen_data_valid;
  logic               gen_frame_valid;
  logic [2*LEN_W-1:0] gen_ctrl;
  logic               gen_hi_priority;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   frames_sent;

  int checks = 0;
  int errors = 0;

  logic [7:0] lfsr_exp [16];

  always #5 clk_sys = ~clk_sys;

  xmit_frame_gen #(
    .DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .EDGE_BYTES(4), .MIN_LEN(8)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_len(cfg_len), .cfg_count(cfg_count), .cfg_gap(cfg_gap), .cfg_mode(cfg_mode),
    .cfg_fill(cfg_fill), .cfg_hi_pri(cfg_hi_pri), .cfg_pri_alt(cfg_pri_alt),
    .gen_stall(gen_stall), .gen_data(gen_data), .gen_data_valid(gen_data_valid),
    .gen_frame_valid(gen_frame_valid), .gen_ctrl(gen_ctrl),
    .gen_hi_priority(gen_hi_priority), .busy(busy), .done(done),
    .frames_sent(frames_sent)
  );

  // Called at a negedge; returns at the next negedge with byte 0 on the outputs.
  task automatic start_run(input logic [LEN_W-1:0] len, input logic [CNT_W-1:0] count,
                           input logic [CNT_W-1:0] gap, input logic [1:0] mode,
                           input logic [7:0] fill, input logic hi, input logic alt);
    cfg_len = len; cfg_count = count; cfg_gap = gap; cfg_mode = mode;
    cfg_fill = fill; cfg_hi_pri = hi; cfg_pri_alt = alt; cfg_start = 1'b1;
    @(negedge clk_sys);
    cfg_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    checks++;
    if ({gen_data, gen_data_valid, gen_frame_valid, gen_ctrl, gen_hi_priority, busy, done, frames_sent} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got data=%h dv=%b fv=%b ctrl=%h pri=%b busy=%b done=%b sent=%0d want all 0",
               gen_data, gen_data_valid, gen_frame_valid, gen_ctrl, gen_hi_priority, busy, done, frames_sent);
    end
    reset = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_fill();
    logic [7:0] exp_b;
    logic [2*LEN_W-1:0] exp_c;
    start_run(12'd64, 8'd1, 8'd0, 2'd0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) begin
      exp_b = (i < 4 || i >= 60) ? 8'h00 : 8'hFF;
      exp_c = (i == 0) ? 24'h040040 : 24'h000000;
      checks++;
      if (gen_data_valid !== 1'b1 || gen_data !== exp_b) begin
        errors++;
        $display("[TB] FAIL fill_byte%0d got dv=%b data=%h want dv=1 data=%h", i, gen_data_valid, gen_data, exp_b);
      end
      checks++;
      if (gen_frame_valid !== (i == 0) || gen_ctrl !== exp_c) begin
        errors++;
        $display("[TB] FAIL fill_ctrl%0d got fv=%b ctrl=%h want fv=%b ctrl=%h", i, gen_frame_valid, gen_ctrl, (i == 0), exp_c);
      end
      checks++;
      if (gen_hi_priority !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL fill_status%0d got pri=%b busy=%b done=%b want 1 1 0", i, gen_hi_priority, busy, done);
      end
      @(negedge clk_sys);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || gen_data_valid !== 1'b0 || frames_sent !== 8'd1) begin
      errors++;
      $display("[TB] FAIL fill_end got done=%b busy=%b dv=%b sent=%0d want 1 0 0 1", done, busy, gen_data_valid, frames_sent);
    end
    @(negedge clk_sys);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fill_done_pulse got done=%b want 0", done);
    end
  endtask

  task automatic test_incr_gap();
    start_run(12'd3, 8'd2, 8'd5, 2'd1, 8'h00, 1'b0, 1'b0);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (gen_data_valid !== 1'b1 || gen_data !== 8'(i) || gen_frame_valid !== (i == 0)) begin
          errors++;
          $display("[TB] FAIL incr_f%0d_byte%0d got dv=%b data=%h fv=%b want 1 %h %b", f, i, gen_data_valid, gen_data, gen_frame_valid, 8'(i), (i == 0));
        end
        if (i == 0) begin
          checks++;
          if (gen_ctrl !== 24'h008008) begin
            errors++;
            $display("[TB] FAIL incr_ctrl_f%0d got %h want 008008", f, gen_ctrl);
          end
        end
        @(negedge clk_sys);
      end
      if (f == 0) begin
        for (int g = 0; g < 5; g++) begin
          checks++;
          if (gen_data_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || frames_sent !== 8'd1) begin
            errors++;
            $display("[TB] FAIL incr_gap%0d got dv=%b busy=%b done=%b sent=%0d want 0 1 0 1", g, gen_data_valid, busy, done, frames_sent);
          end
          @(negedge clk_sys);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || frames_sent !== 8'd2) begin
      errors++;
      $display("[TB] FAIL incr_end got done=%b busy=%b sent=%0d want 1 0 2", done, busy, frames_sent);
    end
    @(negedge clk_sys);
  endtask

  task automatic test_lfsr_stall();
    lfsr_exp = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1, 8'hC2, 8'h85,
                 8'h0B, 8'h17, 8'h2F, 8'h5E, 8'hBC, 8'h78, 8'hF1, 8'hE3};
    start_run(12'd16, 8'd1, 8'd0, 2'd2, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (gen_data_valid !== 1'b1 || gen_data !== lfsr_exp[i] || gen_frame_valid !== (i == 0)) begin
        errors++;
        $display("[TB] FAIL lfsr_byte%0d got dv=%b data=%h fv=%b want 1 %h %b", i, gen_data_valid, gen_data, gen_frame_valid, lfsr_exp[i], (i == 0));
      end
      if (i == 4) begin
        gen_stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk_sys);
          checks++;
          if (gen_data_valid !== 1'b0 || gen_frame_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lfsr_stall%0d got dv=%b fv=%b want 0 0", s, gen_data_valid, gen_frame_valid);
          end
        end
        gen_stall = 1'b0;
      end
      @(negedge clk_sys);
    end
    checks++;
    if (done !== 1'b1 || frames_sent !== 8'd1) begin
      errors++;
      $display("[TB] FAIL lfsr_end got done=%b sent=%0d want 1 1", done, frames_sent);
    end
    @(negedge clk_sys);
  endtask

  task automatic test_stop_pri();
    start_run(12'd8, 8'd0, 8'd0, 2'd3, 8'hA5, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 8; b++) begin
        checks++;
        if (gen_data_valid !== 1'b1 || gen_data !== 8'hA5 || gen_hi_priority !== k[0] || gen_frame_valid !== (b == 0)) begin
          errors++;
          $display("[TB] FAIL stop_f%0d_byte%0d got dv=%b data=%h pri=%b fv=%b want 1 a5 %b %b", k, b, gen_data_valid, gen_data, gen_hi_priority, gen_frame_valid, k[0], (b == 0));
        end
        if (b == 0) begin
          checks++;
          if (frames_sent !== 8'(k)) begin
            errors++;
            $display("[TB] FAIL stop_sent_f%0d got %0d want %0d", k, frames_sent, k);
          end
        end
        if (k == 3 && b == 3) begin
          cfg_stop = 1'b1;
          gen_stall = 1'b1;
          @(negedge clk_sys);
          cfg_stop = 1'b0;
          gen_stall = 1'b0;
          checks++;
          if (gen_data_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stop_stall got dv=%b busy=%b want 0 1", gen_data_valid, busy);
          end
        end
        @(negedge clk_sys);
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || frames_sent !== 8'd4 || gen_data_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stop_end got done=%b busy=%b sent=%0d dv=%b want 1 0 4 0", done, busy, frames_sent, gen_data_valid);
    end
    @(negedge clk_sys);
  endtask

  task automatic test_reset_mid();
    start_run(12'd64, 8'd1, 8'd0, 2'd1, 8'h00, 1'b1, 1'b0);
    repeat (10) @(negedge clk_sys);
    checks++;
    if (gen_data !== 8'h0A || gen_data_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rstmid_byte10 got dv=%b data=%h want 1 0a", gen_data_valid, gen_data);
    end
    reset = 1'b1;
    @(negedge clk_sys);
    checks++;
    if ({gen_data, gen_data_valid, gen_frame_valid, gen_ctrl, gen_hi_priority, busy, done, frames_sent} !== '0) begin
      errors++;
      $display("[TB] FAIL rstmid_outputs got data=%h dv=%b busy=%b done=%b pri=%b want all 0", gen_data, gen_data_valid, busy, done, gen_hi_priority);
    end
    reset = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_nodone got done=%b busy=%b want 0 0", done, busy);
    end
    start_run(12'd8, 8'd1, 8'd0, 2'd1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (gen_data_valid !== 1'b1 || gen_data !== 8'(i) || gen_frame_valid !== (i == 0)) begin
        errors++;
        $display("[TB] FAIL rstmid_new_byte%0d got dv=%b data=%h fv=%b want 1 %h %b", i, gen_data_valid, gen_data, gen_frame_valid, 8'(i), (i == 0));
      end
      @(negedge clk_sys);
    end
    checks++;
    if (done !== 1'b1 || frames_sent !== 8'd1) begin
      errors++;
      $display("[TB] FAIL rstmid_new_end got done=%b sent=%0d want 1 1", done, frames_sent);
    end
    @(negedge clk_sys);
  endtask

  task automatic test_start_busy();
    start_run(12'd8, 8'd2, 8'd2, 2'd1, 8'h00, 1'b1, 1'b0);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (gen_data_valid !== 1'b1 || gen_data !== 8'(i) || gen_hi_priority !== 1'b1) begin
          errors++;
          $display("[TB] FAIL busy_f%0d_byte%0d got dv=%b data=%h pri=%b want 1 %h 1", f, i, gen_data_valid, gen_data, gen_hi_priority, 8'(i));
        end
        if (f == 0 && i == 3) begin
          cfg_len = 12'd20; cfg_count = 8'd1; cfg_gap = 8'd0; cfg_mode = 2'd3;
          cfg_fill = 8'h3C; cfg_hi_pri = 1'b0; cfg_start = 1'b1;
        end else begin
          cfg_start = 1'b0;
        end
        @(negedge clk_sys);
      end
      if (f == 0) begin
        for (int g = 0; g < 2; g++) begin
          checks++;
          if (gen_data_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_gap%0d got dv=%b busy=%b want 0 1", g, gen_data_valid, busy);
          end
          @(negedge clk_sys);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || frames_sent !== 8'd2) begin
      errors++;
      $display("[TB] FAIL busy_end got done=%b busy=%b sent=%0d want 1 0 2", done, busy, frames_sent);
    end
    @(negedge clk_sys);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_incr_gap();
    test_lfsr_stall();
    test_stop_pri();
    test_reset_mid();
    test_start_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xmit_frame_gen.md
# xmit_frame_gen

Synthesizable, parametrised transmit-frame source for the xmit path: it drives the same frame/data/priority/control interface that the receive side presents to `xmitTop`. It generates configurable bursts of frames with programmable length, priority policy, payload pattern and inter-frame gap. Stall handling lets it stand in for upstream traffic in on-chip self-test and in regression benches. It sits in the `clk_sys` domain directly ahead of `xmitTop`.

## Interface
- `DATA_W`, default 8: data width; must be a multiple of 8; every byte lane carries the same pattern byte.
- `LEN_W`, default 12: frame-length field width, in bytes.
- `CNT_W`, default 8: width of the frame-count and gap fields.
- `EDGE_BYTES`, default 4: number of head and tail bytes in FILL mode.
- `MIN_LEN`, default 8: minimum frame length; must be at least 2*`EDGE_BYTES`.
- `clk_sys`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cfg_start`  in  1  one-cycle pulse; latches all `cfg_*` inputs; honoured only in IDLE.
- `cfg_stop`  in  1  ends the run after the current frame completes.
- `cfg_len`  in  LEN_W  frame length in bytes.
- `cfg_count`  in  CNT_W  number of frames to send; 0 means continuous until `cfg_stop`.
- `cfg_gap`  in  CNT_W  idle cycles inserted between frames.
- `cfg_mode`  in  2  payload pattern: 0 FILL, 1 INCR, 2 LFSR, 3 CONST.
- `cfg_fill`  in  8  payload byte used in CONST mode.
- `cfg_hi_pri`  in  1  priority of the first frame.
- `cfg_pri_alt`  in  1  when 1, priority toggles on every frame.
- `gen_stall`  in  1  downstream hold request.
- `gen_data`  out  DATA_W  payload data.
- `gen_data_valid`  out  1  `gen_data` is valid this cycle.
- `gen_frame_valid`  out  1  high on the first byte of each frame only.
- `gen_ctrl`  out  2*LEN_W  control word, {length, length}; valid when `gen_frame_valid` is high, 0 otherwise.
- `gen_hi_priority`  out  1  priority of the current frame; held stable for the whole frame.
- `busy`  out  1  a run is in progress.
- `done`  out  1  one-cycle pulse when a run ends.
- `frames_sent`  out  CNT_W  frames completed in the current run; wraps modulo 2^CNT_W.

## Operation
- FSM states: IDLE, DATA, GAP.
- IDLE + `cfg_start`: latch config; effective length is max(`cfg_len`, `MIN_LEN`); clear `frames_sent`; go to DATA.
- DATA: presents byte index i = 0 .. len-1.
  - At i = 0, `gen_frame_valid` = 1 and `gen_ctrl` = {len, len}, in the same cycle as the first data byte.
  - After i = len-1, `frames_sent` increments.
  - Next state is GAP if `cfg_gap` > 0, otherwise DATA again for the next frame.
  - The run ends instead (go to IDLE, pulse `done`) when `frames_sent`+1 == `cfg_count` (with `cfg_count` ≠ 0) or when `stop_pend` is set.
- GAP: idle for `cfg_gap` cycles, then DATA; the same end-of-run check applies at GAP exit.
- `gen_stall` in DATA:
  - `gen_data_valid` and `gen_frame_valid` go low and i holds.
  - The byte presented after release equals the byte that was withheld.
- `gen_stall` in GAP and IDLE has no effect.
- `cfg_stop` sets a sticky `stop_pend`; the frame in flight always completes. `stop_pend` clears on return to IDLE.
- `cfg_start` outside IDLE is ignored.
- Payload patterns:
  - FILL: 0x00 for i < `EDGE_BYTES` and for i ≥ len-`EDGE_BYTES`; 0xFF otherwise.
  - INCR: byte = i[7:0].
  - LFSR: 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, seeded 0xFF at i = 0 and advanced per presented byte.
  - CONST: byte = `cfg_fill`.
- Priority: frame k uses `cfg_hi_pri` XOR (`cfg_pri_alt` AND k[0]).

## Timing
- Reset values: all outputs 0; state IDLE; `stop_pend` 0.
- Reset asserted mid-frame aborts immediately. Outputs are 0 on the next edge; no partial frame completes and `done` does not pulse.
- The first byte appears on the cycle after the `cfg_start` edge (1-cycle latency).
- With no stall, a frame occupies exactly len cycles of contiguous `gen_data_valid`.
- The next frame's first byte follows `cfg_gap` cycles after the last byte; back-to-back frames when `cfg_gap` = 0.
- `done` and `busy` falling occur on the cycle after the last byte, or after the last GAP cycle if the run ends in GAP.
- Stall and stop arriving in the same cycle: both take effect.
- All outputs are registered.

## Structure
- Package `xmit_gen_pkg`: mode enum (FILL/INCR/LFSR/CONST), FSM state enum, LFSR tap constant, FILL head/tail byte values (0x00, 0xFF).
- Sub-module `xmit_pattern_gen`: combinational/registered byte generator from (mode, i, len, lfsr state); handles the LFSR advance and hold.

## Test plan
- Reset, then start with len=64, FILL, `cfg_hi_pri`=1, count=1, gap=0 → `gen_ctrl`=0x040040 with frame_valid on byte 0; bytes 0-3 = 0x00, 4-59 = 0xFF, 60-63 = 0x00; priority 1 throughout; `done` one cycle after byte 63.
- len=3, INCR, count=2, gap=5 → each frame 8 bytes 0x00..0x07; `gen_ctrl`=0x008008; exactly 5 idle cycles between frames; `frames_sent`=2.
- LFSR, len=16, stall asserted for 3 cycles at i=5 → byte sequence identical to an unstalled run; valid low for 3 cycles; no frame_valid re-pulse.
- count=0, `cfg_pri_alt`=1, CONST 0xA5, `cfg_stop` at mid-frame 3 → frames 0-3 complete, priorities 0,1,0,1; ends after frame 3; `frames_sent`=4.
- `reset` asserted at i=10 of a 64-byte frame → all outputs 0 next cycle, no `done`; a new start then produces a clean full frame.
- `cfg_start` pulsed while busy → ignored; the run's config and count are unchanged.
